// File: rtl/prefetch_buffer_if.sv
// Handshake/window bundle between fetch stage, prefetch buffer and length decoder.
// master = fetch/decode side, slave = the buffer.
interface prefetch_buffer_if #(
    parameter int FETCH_BYTES = 16,
    parameter int ADDR_WIDTH  = 32
);
    localparam int CW = $clog2(FETCH_BYTES) + 1;

    logic                     fb_valid;
    logic                     fb_ready;
    logic [FETCH_BYTES*8-1:0] fb_data;
    logic [ADDR_WIDTH-1:0]    fb_pc;
    logic [CW-2:0]            fb_offset;
    logic                     flush;
    logic [CW-1:0]            win_bytes;
    logic [FETCH_BYTES*8-1:0] win_data;
    logic [ADDR_WIDTH-1:0]    win_pc;
    logic [CW-1:0]            consume;

    modport master (
        output fb_valid, fb_data, fb_pc, fb_offset, flush, consume,
        input  fb_ready, win_bytes, win_data, win_pc
    );

    modport slave (
        input  fb_valid, fb_data, fb_pc, fb_offset, flush, consume,
        output fb_ready, win_bytes, win_data, win_pc
    );
endinterface

// File: rtl/prefetch_buffer.sv
// Byte-granular fetch-block queue presenting a sliding instruction-byte window.
// Define PFB_BYPASS_EN to let a block entering an empty buffer show in the window the same cycle.
module prefetch_buffer #(
    parameter int FETCH_BYTES = 16,
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int CW          = $clog2(FETCH_BYTES) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    prefetch_buffer_if.slave bus
);
    localparam int W  = FETCH_BYTES * 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam int BW = CW - 1;
    localparam logic [CW-1:0] FB = CW'(FETCH_BYTES);

    logic [W-1:0]          data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [NW-1:0]         count_q, count_d;
    logic [BW-1:0]         bp_q, bp_d;

    logic [PW-1:0]   next_idx;
    logic [2*W-1:0]  pair, shifted;
    logic            byp, push, write, pop, wrap, load_off;
    logic [CW-1:0]   c, s;
    logic [BW-1:0]   base_bp;

    assign bus.fb_ready = (count_q != NW'(DEPTH));
    assign next_idx     = head_q + 1'b1;
    assign pair         = {data_q[next_idx], data_q[head_q]};
    assign shifted      = pair >> {bp_q, 3'b000};

`ifdef PFB_BYPASS_EN
    assign byp = (count_q == '0) && bus.fb_valid && !bus.flush;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        bus.win_bytes = '0;
        bus.win_data  = '0;
        bus.win_pc    = '0;
        if (count_q != '0) begin
            bus.win_bytes = (count_q == NW'(1)) ? (FB - {1'b0, bp_q}) : FB;
            bus.win_data  = shifted[W-1:0];
            bus.win_pc    = pc_q[head_q] | ADDR_WIDTH'(bp_q);
        end
`ifdef PFB_BYPASS_EN
        if (byp) begin
            bus.win_bytes = FB - {1'b0, bus.fb_offset};
            bus.win_data  = bus.fb_data >> {bus.fb_offset, 3'b000};
            bus.win_pc    = bus.fb_pc | ADDR_WIDTH'(bus.fb_offset);
        end
`endif
    end

    // s < 2*FETCH_BYTES always, so its top bit flags a pop and the low bits are the new bp.
    always_comb begin
        c        = (bus.consume > bus.win_bytes) ? bus.win_bytes : bus.consume;
        base_bp  = byp ? bus.fb_offset : bp_q;
        s        = {1'b0, base_bp} + c;
        wrap     = s[CW-1];
        push     = bus.fb_valid && bus.fb_ready && !bus.flush;
        write    = push && !(byp && wrap);
        pop      = wrap && !byp;
        load_off = write && ((count_q == '0) || ((count_q == NW'(1)) && pop));
        count_d  = count_q + NW'(write) - NW'(pop);
        head_d   = head_q + PW'(pop);
        tail_d   = tail_q + PW'(write);
        bp_d     = (load_off && !byp) ? bus.fb_offset : s[BW-1:0];
        if (bus.flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            bp_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            bp_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            bp_q    <= bp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (write) begin
            data_q[tail_q] <= bus.fb_data;
            pc_q[tail_q]   <= bus.fb_pc;
        end
    end
endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer; expectations follow the bypass macro setting.
module tb_prefetch_buffer;
    localparam int FB = 16;
    localparam int D  = 4;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    logic [255:0] pair;
    logic [127:0] tmp;

    always #5 clk = ~clk;

    prefetch_buffer_if #(.FETCH_BYTES(FB), .ADDR_WIDTH(AW)) bus ();

    prefetch_buffer #(
        .FETCH_BYTES(FB),
        .DEPTH      (D),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic logic [127:0] blk(input logic [31:0] pc);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(pc[11:4] * 17 + k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
        bus.fb_valid  = 1'b0;
        bus.consume   = '0;
        bus.flush     = 1'b0;
        bus.fb_offset = '0;
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [3:0] off);
        bus.fb_valid  = 1'b1;
        bus.fb_pc     = pc;
        bus.fb_data   = blk(pc);
        bus.fb_offset = off;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.fb_valid  = 1'b0;
        bus.fb_data   = '0;
        bus.fb_pc     = '0;
        bus.fb_offset = '0;
        bus.flush     = 1'b0;
        bus.consume   = '0;
        #3;
        chk("rst_ready", bus.fb_ready, 1);
        chk("rst_bytes", bus.win_bytes, 0);
        chk("rst_data", bus.win_data, 0);
        chk("rst_pc", bus.win_pc, 0);
        #5 rst_n = 1'b1;
        clk_edge();
        chk("idle_bytes", bus.win_bytes, 0);
        chk("idle_ready", bus.fb_ready, 1);

        // two contiguous blocks, partial then crossing consume
        offer(32'h100, 0);
        #1;
`ifdef PFB_BYPASS_EN
        chk("first_byp_bytes", bus.win_bytes, 16);
`else
        chk("first_nobyp_bytes", bus.win_bytes, 0);
`endif
        clk_edge();
        offer(32'h110, 0);
        clk_edge();
        chk("two_bytes", bus.win_bytes, 16);
        chk("two_pc", bus.win_pc, 32'h100);
        chk("two_data", bus.win_data, blk(32'h100));
        bus.consume = 5;
        clk_edge();
        pair = {blk(32'h110), blk(32'h100)};
        chk("c5_pc", bus.win_pc, 32'h105);
        chk("c5_bytes", bus.win_bytes, 16);
        chk("c5_data", bus.win_data, pair[40 +: 128]);
        chk("c5_byte0", bus.win_data[7:0], 8'h15);
        chk("c5_byte11", bus.win_data[95:88], 8'h21);
        bus.consume = 11;
        clk_edge();
        chk("c11_pc", bus.win_pc, 32'h110);
        chk("c11_bytes", bus.win_bytes, 16);
        chk("c11_data", bus.win_data, blk(32'h110));
        bus.consume = 9;
        clk_edge();
        tmp = blk(32'h110);
        chk("c9_bytes", bus.win_bytes, 7);
        chk("c9_pc", bus.win_pc, 32'h119);
        chk("c9_data", bus.win_data[55:0], tmp[127:72]);
        bus.consume = 20;
        clk_edge();
        chk("clamp_bytes", bus.win_bytes, 0);
        chk("clamp_pc", bus.win_pc, 0);
        chk("clamp_data", bus.win_data, 0);
        chk("clamp_ready", bus.fb_ready, 1);
        bus.consume = 16;
        clk_edge();
        chk("empty_consume", bus.win_bytes, 0);

        // fill to DEPTH, hold off, then pop and push with pointer wrap
        for (int i = 0; i < 4; i++) begin
            offer(32'h120 + 32'(16 * i), 0);
            clk_edge();
        end
        chk("full_ready", bus.fb_ready, 0);
        chk("full_pc", bus.win_pc, 32'h120);
        chk("full_bytes", bus.win_bytes, 16);
        offer(32'h160, 0);
        clk_edge();
        chk("held_ready", bus.fb_ready, 0);
        chk("held_pc", bus.win_pc, 32'h120);
        offer(32'h160, 0);
        bus.consume = 16;
        clk_edge();
        chk("pop_full_ready", bus.fb_ready, 1);
        chk("pop_full_pc", bus.win_pc, 32'h130);
        offer(32'h160, 0);
        bus.consume = 16;
        clk_edge();
        chk("pushpop_ready", bus.fb_ready, 1);
        chk("pushpop_pc", bus.win_pc, 32'h140);
        bus.consume = 16;
        clk_edge();
        chk("drain1_pc", bus.win_pc, 32'h150);
        bus.consume = 16;
        clk_edge();
        chk("drain2_pc", bus.win_pc, 32'h160);
        chk("drain2_data", bus.win_data, blk(32'h160));
        bus.consume = 16;
        clk_edge();
        chk("drain3_bytes", bus.win_bytes, 0);

        // flush with count=3 drops the flush-cycle block and consume
        for (int i = 0; i < 3; i++) begin
            offer(32'h170 + 32'(16 * i), 0);
            clk_edge();
        end
        chk("pre_flush_pc", bus.win_pc, 32'h170);
        offer(32'h1a0, 0);
        bus.consume = 4;
        bus.flush   = 1'b1;
        clk_edge();
        chk("flush_bytes", bus.win_bytes, 0);
        chk("flush_ready", bus.fb_ready, 1);
        clk_edge();
        chk("flush_absent", bus.win_bytes, 0);
        offer(32'h200, 6);
        #1;
`ifdef PFB_BYPASS_EN
        chk("redir_byp_bytes", bus.win_bytes, 10);
        chk("redir_byp_pc", bus.win_pc, 32'h206);
`else
        chk("redir_nobyp_bytes", bus.win_bytes, 0);
`endif
        clk_edge();
        tmp = blk(32'h200);
        chk("redir_pc", bus.win_pc, 32'h206);
        chk("redir_bytes", bus.win_bytes, 10);
        chk("redir_data", bus.win_data[79:0], tmp[127:48]);
        bus.consume = 10;
        clk_edge();
        chk("redir_drain", bus.win_bytes, 0);

        // push into empty buffer with full consume in the same cycle
        offer(32'h300, 0);
        bus.consume = 16;
        #1;
`ifdef PFB_BYPASS_EN
        chk("byp_same_bytes", bus.win_bytes, 16);
        chk("byp_same_pc", bus.win_pc, 32'h300);
        chk("byp_same_data", bus.win_data, blk(32'h300));
        clk_edge();
        chk("byp_after_bytes", bus.win_bytes, 0);
        chk("byp_after_ready", bus.fb_ready, 1);
`else
        chk("nobyp_same_bytes", bus.win_bytes, 0);
        clk_edge();
        chk("nobyp_after_bytes", bus.win_bytes, 16);
        chk("nobyp_after_pc", bus.win_pc, 32'h300);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
